// File: rtl/hm2_adaptor_pkg.sv
// Shared types and helpers for the HostMot2 port adaptor.
package hm2_adaptor_pkg;

  typedef enum logic {ADP_STRAIGHT = 1'b0, ADP_DB25 = 1'b1} adp_mode_e;
  typedef enum logic [1:0] {IDLE, GUARD, APPLY} adp_state_e;

  // Widest port the live-pin mask helper can describe.
  localparam int MAX_PORT_W = 64;

  // Mode register read-back layout.
  localparam int RD_FIELD_W     = 8;
  localparam int RD_ACTIVE_LSB  = 0;
  localparam int RD_PENDING_LSB = 16;
  localparam int RD_BUSY_BIT    = 31;

  // Live-pin mask of one port: all pins in STRAIGHT, the low db25_pins in DB25.
  function automatic logic [MAX_PORT_W-1:0] port_mask(input logic [7:0] mode,
                                                       input int port,
                                                       input int db25_pins);
    if (adp_mode_e'(mode[port[2:0]]) == ADP_DB25)
      return (64'd1 << db25_pins) - 64'd1;
    return '1;
  endfunction

endpackage

// File: rtl/hm2_pin_sync.sv
// Per-bit multi-flop input synchroniser.
module hm2_pin_sync #(
  parameter int Width  = 1,
  parameter int Stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Stages-1:0][Width-1:0] pipe;

  // Shift raw pins through Stages flops; the last stage is the clean value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[Stages-2:0], d};
  end

  assign q = pipe[Stages-1];

endmodule

// File: rtl/hm2_port_adaptor.sv
// Maps the flat HostMot2 I/O bus onto GPIO headers with a per-port
// STRAIGHT/DB25 mode and a break-before-make guard on mode changes.
module hm2_port_adaptor
  import hm2_adaptor_pkg::*;
#(
  parameter int IOPorts     = 3,
  parameter int PortWidth   = 24,
  parameter int NumGPIO     = 2,
  parameter int GPIOWidth   = 36,
  parameter int DB25Pins    = 17,
  parameter int GuardCycles = 4,
  parameter int SyncStages  = 2,
  parameter logic [IOPorts-1:0] DefaultMode = '0,
  parameter int AddrWidth   = 16,
  parameter int BusWidth    = 32,
  parameter logic [AddrWidth-1:0] ModeAddr = 'h0100
) (
  input  logic                           clklow,
  input  logic                           reset_n,
  input  logic [AddrWidth-1:0]           bus_addr,
  input  logic [BusWidth-1:0]            bus_wdata,
  input  logic                           bus_we,
  input  logic                           bus_re,
  output logic [BusWidth-1:0]            bus_rdata,
  input  logic [IOPorts*PortWidth-1:0]   hm2_out,
  input  logic [IOPorts*PortWidth-1:0]   hm2_oe,
  output logic [IOPorts*PortWidth-1:0]   hm2_in,
  output logic [NumGPIO*GPIOWidth-1:0]   gpio_out,
  output logic [NumGPIO*GPIOWidth-1:0]   gpio_oe,
  input  logic [NumGPIO*GPIOWidth-1:0]   gpio_in,
  output logic                           busy
);

  localparam int MAP = IOPorts * PortWidth;
  localparam int TOT = NumGPIO * GPIOWidth;

  if (MAP > TOT || DB25Pins > PortWidth || IOPorts > 8 || IOPorts < 1 ||
      PortWidth > MAX_PORT_W || BusWidth < 32 || SyncStages < 2 ||
      SyncStages > 4 || GuardCycles < 1 || GuardCycles > 255) begin : g_bad_cfg
    $fatal(1, "hm2_port_adaptor: invalid parameter combination");
  end

  adp_state_e         state, state_nxt;
  logic [IOPorts-1:0] active, pending, active_nxt, pending_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic [IOPorts-1:0] wr_mode, eff_mode, guard_ports;
  logic               mode_wr;

  assign mode_wr = bus_we && (bus_addr == ModeAddr);
  assign wr_mode = bus_wdata[IOPorts-1:0];
  assign busy    = (state != IDLE);

  // During APPLY the pins already take the incoming mode so the old
  // mode is never re-enabled between guard and switch-over.
  assign eff_mode    = (state == APPLY) ? pending : active;
  assign guard_ports = (state == GUARD) ? (pending ^ active) : '0;

  // Mode FSM state and registers.
  always_ff @(posedge clklow or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      active  <= DefaultMode;
      pending <= DefaultMode;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      active  <= active_nxt;
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Next-state: IDLE also catches a write that landed during APPLY,
  // since that is the only way pending can differ from active there.
  always_comb begin
    state_nxt   = state;
    active_nxt  = active;
    pending_nxt = pending;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        if (mode_wr) pending_nxt = wr_mode;
        if ((mode_wr ? wr_mode : pending) != active) begin
          state_nxt = GUARD;
          cnt_nxt   = 8'(GuardCycles);
        end
      end
      GUARD: begin
        if (mode_wr) begin
          pending_nxt = wr_mode;
          if (wr_mode == active) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = 8'(GuardCycles);
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
          if (cnt <= 8'd1) state_nxt = APPLY;
        end
      end
      APPLY: begin
        active_nxt = pending;
        state_nxt  = IDLE;
        if (mode_wr) pending_nxt = wr_mode;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Live-pin masks: outputs use the effective mode plus guard, inputs the active mode.
  logic [MAP-1:0] out_live, in_live;

  for (genvar p = 0; p < IOPorts; p++) begin : g_port
    logic [MAX_PORT_W-1:0] pm_eff, pm_act;
    assign pm_eff = port_mask(8'(eff_mode), p, DB25Pins);
    assign pm_act = port_mask(8'(active), p, DB25Pins);
    assign out_live[p*PortWidth +: PortWidth] =
      pm_eff[PortWidth-1:0] & {PortWidth{~guard_ports[p]}};
    assign in_live[p*PortWidth +: PortWidth] = pm_act[PortWidth-1:0];
    if (PortWidth < MAX_PORT_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{pm_eff[MAX_PORT_W-1:PortWidth], pm_act[MAX_PORT_W-1:PortWidth]};
    end
  end

  logic [MAP-1:0] out_q, oe_q;

  // Registered, masked output path.
  always_ff @(posedge clklow or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      out_q <= hm2_out & out_live;
      oe_q  <= hm2_oe & out_live;
    end
  end

  // Unmapped header pins stay zero.
  assign gpio_out = TOT'(out_q);
  assign gpio_oe  = TOT'(oe_q);

  logic [TOT-1:0] sync_q;

  hm2_pin_sync #(.Width(TOT), .Stages(SyncStages)) u_sync (
    .clk   (clklow),
    .rst_n (reset_n),
    .d     (gpio_in),
    .q     (sync_q)
  );

  assign hm2_in = sync_q[MAP-1:0] & in_live;

  if (TOT > MAP) begin : g_spare
    logic unused_sync;
    assign unused_sync = ^sync_q[TOT-1:MAP];
  end

  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[BusWidth-1:IOPorts];

  logic [31:0] rd_word;

  // Read-back word: active, pending and busy fields.
  always_comb begin
    rd_word = '0;
    rd_word[RD_ACTIVE_LSB  +: RD_FIELD_W] = RD_FIELD_W'(active);
    rd_word[RD_PENDING_LSB +: RD_FIELD_W] = RD_FIELD_W'(pending);
    rd_word[RD_BUSY_BIT]                  = busy;
  end

  // Read data registered one cycle after the strobe; pre-write values on a same-cycle write.
  always_ff @(posedge clklow or negedge reset_n) begin
    if (!reset_n)                              bus_rdata <= '0;
    else if (bus_re && bus_addr == ModeAddr)   bus_rdata <= BusWidth'(rd_word);
    else                                       bus_rdata <= '0;
  end

endmodule

// File: tb/tb_hm2_port_adaptor.sv
// Self-checking bench for hm2_port_adaptor (default parameters).
module tb_hm2_port_adaptor;

  localparam int PW = 24;
  localparam int MAPW = 72;
  localparam int GC = 4;
  localparam logic [15:0] MADDR = 16'h0100;
  localparam logic [71:0] ONES = {72{1'b1}};
  localparam logic [71:0] PAT_AA = {9{8'hAA}};

  logic        clklow = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0, bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic [71:0] hm2_out = '0, hm2_oe = '0, hm2_in;
  logic [71:0] gpio_out, gpio_oe, gpio_in = '0;
  logic        busy;

  hm2_port_adaptor dut (
    .clklow(clklow), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .hm2_out(hm2_out),
    .hm2_oe(hm2_oe), .hm2_in(hm2_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .gpio_in(gpio_in), .busy(busy)
  );

  always #5 clklow = ~clklow;

  int n_cmp = 0, n_bad = 0;

  // Reference model: mode registers plus a countdown of remaining guard cycles.
  logic [2:0]  m_active, m_pending;
  int          m_guard;
  bit          m_apply;
  logic [71:0] e_out, e_oe, e_in, g_prev;
  logic [31:0] e_rdata;
  logic        e_busy;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic live(input logic [2:0] mode, input int pin);
    if (pin >= MAPW) return 1'b0;
    return !(mode[pin / PW] && (pin % PW) >= 17);
  endfunction

  task automatic model_reset();
    m_active = 3'b000; m_pending = 3'b000; m_guard = 0; m_apply = 0;
    e_out = '0; e_oe = '0; e_in = '0; g_prev = '0; e_rdata = '0; e_busy = 0;
  endtask

  // Predict post-edge outputs from the current inputs and model state.
  task automatic model_edge();
    logic [2:0] eff, chg, w;
    logic [71:0] m, im;
    logic bnow, wr;
    bnow = (m_guard > 0) || m_apply;
    eff  = m_apply ? m_pending : m_active;
    chg  = (m_guard > 0) ? (m_pending ^ m_active) : 3'b000;
    for (int i = 0; i < 72; i++)
      m[i] = live(eff, i) && !(i < MAPW && chg[i / PW]);
    e_out = hm2_out & m;
    e_oe  = hm2_oe & m;
    e_rdata = (bus_re && bus_addr == MADDR) ?
              {bnow, 7'b0, 5'b0, m_pending, 8'b0, 5'b0, m_active} : 32'h0;
    wr = bus_we && bus_addr == MADDR;
    w  = bus_wdata[2:0];
    if (m_apply) begin
      m_active = m_pending; m_apply = 0;
      if (wr) m_pending = w;
    end else if (m_guard > 0) begin
      if (wr) begin
        m_pending = w;
        m_guard = (w == m_active) ? 0 : GC;
      end else if (m_guard == 1) begin
        m_guard = 0; m_apply = 1;
      end else m_guard--;
    end else begin
      if (wr) m_pending = w;
      if (m_pending != m_active) m_guard = GC;
    end
    for (int i = 0; i < 72; i++) im[i] = live(m_active, i);
    e_in = g_prev & im;
    g_prev = gpio_in;
    e_busy = (m_guard > 0) || m_apply;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clklow); #1;
    chk("gpio_oe", gpio_oe, e_oe);
    chk("gpio_out", gpio_out, e_out);
    chk("hm2_in", hm2_in, e_in);
    chk("busy", 72'(busy), 72'(e_busy));
    chk("bus_rdata", 72'(bus_rdata), 72'(e_rdata));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; bus_we = 0; bus_re = 0;
    #3;
    model_reset();
    chk("rst_oe", gpio_oe, 72'h0);
    chk("rst_out", gpio_out, 72'h0);
    chk("rst_in", hm2_in, 72'h0);
    chk("rst_busy", 72'(busy), 72'h0);
    chk("rst_rdata", 72'(bus_rdata), 72'h0);
    @(negedge clklow); reset_n = 1'b1;
  endtask

  task automatic wr_mode(input logic [2:0] v);
    bus_we = 1; bus_addr = MADDR; bus_wdata = {29'h0, v};
  endtask

  task automatic idle_bus();
    bus_we = 0; bus_re = 0; bus_addr = MADDR;
  endtask

  typedef struct {
    logic        we, re;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_busy;
    logic [23:0] exp_oe1;
    logic [23:0] exp_in1;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tv[12];
  int bcnt;

  initial begin
    // Mode-change walk from STRAIGHT to port 1 in DB25 with all oe set and inputs high.
    tv[0]  = '{1, 0, 16'h0100, 32'h2, 1, 24'hFFFFFF, 24'hFFFFFF, 32'h0};
    tv[1]  = '{0, 0, 16'h0100, 32'h0, 1, 24'h000000, 24'hFFFFFF, 32'h0};
    tv[2]  = '{0, 0, 16'h0100, 32'h0, 1, 24'h000000, 24'hFFFFFF, 32'h0};
    tv[3]  = '{0, 0, 16'h0100, 32'h0, 1, 24'h000000, 24'hFFFFFF, 32'h0};
    tv[4]  = '{0, 0, 16'h0100, 32'h0, 1, 24'h000000, 24'hFFFFFF, 32'h0};
    tv[5]  = '{0, 0, 16'h0100, 32'h0, 0, 24'h01FFFF, 24'h01FFFF, 32'h0};
    tv[6]  = '{0, 1, 16'h0100, 32'h0, 0, 24'h01FFFF, 24'h01FFFF, 32'h0002_0002};
    tv[7]  = '{0, 1, 16'h0104, 32'h0, 0, 24'h01FFFF, 24'h01FFFF, 32'h0};
    tv[8]  = '{1, 0, 16'h0200, 32'h0, 0, 24'h01FFFF, 24'h01FFFF, 32'h0};
    tv[9]  = '{1, 0, 16'h0100, 32'h2, 0, 24'h01FFFF, 24'h01FFFF, 32'h0};
    tv[10] = '{1, 1, 16'h0100, 32'h0, 1, 24'h01FFFF, 24'h01FFFF, 32'h0002_0002};
    tv[11] = '{0, 0, 16'h0100, 32'h0, 1, 24'h000000, 24'h01FFFF, 32'h0};

    model_reset();
    hm2_oe = '0; hm2_out = '0; gpio_in = '0; idle_bus();
    do_reset();

    // Straight pass-through and idle read-back.
    hm2_oe = ONES; hm2_out = PAT_AA;
    cyc();
    chk("pass_oe", gpio_oe, ONES);
    chk("pass_out", gpio_out, PAT_AA);
    bus_re = 1; cyc(); bus_re = 0;
    chk("rd_reset", 72'(bus_rdata), 72'h0);

    // Single-cycle input pulse on pin 5.
    gpio_in = 72'h20; cyc();
    chk("pulse_c1", 72'(hm2_in[5]), 72'h0);
    gpio_in = '0; cyc();
    chk("pulse_c2", 72'(hm2_in[5]), 72'h1);
    cyc();
    chk("pulse_c3", 72'(hm2_in[5]), 72'h0);

    // Table walk.
    gpio_in = ONES; cyc(); cyc();
    for (int i = 0; i < 12; i++) begin
      bus_we = tv[i].we; bus_re = tv[i].re; bus_addr = tv[i].addr; bus_wdata = tv[i].wdata;
      cyc();
      chk($sformatf("tv%0d_busy", i), 72'(busy), 72'(tv[i].exp_busy));
      chk($sformatf("tv%0d_oe1", i), 72'(gpio_oe[47:24]), 72'(tv[i].exp_oe1));
      chk($sformatf("tv%0d_oe02", i), {gpio_oe[71:48], gpio_oe[23:0]}, 72'({48{1'b1}}));
      chk($sformatf("tv%0d_in1", i), 72'(hm2_in[47:24]), 72'(tv[i].exp_in1));
      chk($sformatf("tv%0d_rdata", i), 72'(bus_rdata), 72'(tv[i].exp_rdata));
    end
    idle_bus();
    for (int i = 0; i < 20 && e_busy; i++) cyc();

    // Guard reload: 010 then 110 two cycles later.
    gpio_in = '0; do_reset();
    wr_mode(3'b010); cyc(); bcnt = busy;
    idle_bus(); cyc(); bcnt += busy;
    wr_mode(3'b110); cyc(); bcnt += busy;
    idle_bus();
    cyc(); bcnt += busy;
    chk("reload_oe12", gpio_oe[71:24], 72'h0);
    chk("reload_oe0", 72'(gpio_oe[23:0]), 72'hFFFFFF);
    for (int i = 0; i < 20 && busy; i++) begin cyc(); bcnt += busy; end
    chk("reload_busy_cycles", 72'(bcnt), 72'd7);
    bus_re = 1; cyc(); bus_re = 0;
    chk("reload_rd", 72'(bus_rdata), 72'h0006_0006);

    // Abort: 001 then 000 one cycle later.
    do_reset();
    wr_mode(3'b001); cyc();
    chk("abort_busy1", 72'(busy), 72'h1);
    wr_mode(3'b000); cyc();
    chk("abort_busy0", 72'(busy), 72'h0);
    chk("abort_oe0_off", 72'(gpio_oe[23:0]), 72'h0);
    idle_bus(); cyc();
    chk("abort_oe0_back", 72'(gpio_oe[23:0]), 72'hFFFFFF);
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin cyc(); bcnt += busy; end
    chk("abort_no_apply", 72'(bcnt), 72'h0);
    bus_re = 1; cyc(); bus_re = 0;
    chk("abort_rd", 72'(bus_rdata), 72'h0);

    // Reset in the middle of a guard sequence.
    wr_mode(3'b011); cyc(); idle_bus(); cyc();
    reset_n = 1'b0; #1;
    chk("midrst_oe", gpio_oe, 72'h0);
    chk("midrst_busy", 72'(busy), 72'h0);
    do_reset();
    bus_re = 1; cyc(); bus_re = 0;
    chk("midrst_rd", 72'(bus_rdata), 72'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus_we = ($urandom_range(0, 5) == 0);
      bus_re = ($urandom_range(0, 3) == 0);
      bus_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : MADDR;
      bus_wdata = $urandom;
      hm2_out = {$urandom, $urandom, $urandom};
      hm2_oe  = {$urandom, $urandom, $urandom};
      gpio_in = {$urandom, $urandom, $urandom};
      cyc();
    end
    idle_bus(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hm2_port_adaptor.md
Name: hm2_port_adaptor

Overview:
- Parametrised successor to the fixed per-board I/O mapping. Maps the flat HostMot2 I/O bus (IOPorts × PortWidth) onto NumGPIO physical GPIO headers.
- Per-port adaptor mode is selectable at runtime over the HostMot2 bus: STRAIGHT, or DB25 (17 pins live).
- Sits between the HostMot2 core and the top-level pin ring.
- Adds multi-stage input synchronisation and a break-before-make guard sequence on mode changes.

Parameters:
- IOPorts, 3, number of logical ports (1..8).
- PortWidth, 24, pins per port.
- NumGPIO, 2, number of GPIO headers.
- GPIOWidth, 36, pins per header.
- DB25Pins, 17, live pins per port in DB25 mode.
- GuardCycles, 4, tristate hold cycles on a mode change (1..255).
- SyncStages, 2, input synchroniser depth (2..4).
- DefaultMode, 0, reset value of the per-port mode vector (bit=1 means DB25).
- AddrWidth, 16, bus address width.
- BusWidth, 32, bus data width.
- ModeAddr, 16'h0100, register address.

Ports:
- clklow  in  1  system clock; all logic in this single domain
- reset_n  in  1  asynchronous, active-low reset
- bus_addr  in  AddrWidth  register address
- bus_wdata  in  BusWidth  write data
- bus_we  in  1  write strobe, one cycle
- bus_re  in  1  read strobe, one cycle
- bus_rdata  out  BusWidth  read data, valid the cycle after bus_re
- hm2_out  in  IOPorts*PortWidth  core output data
- hm2_oe  in  IOPorts*PortWidth  core output enables
- hm2_in  out  IOPorts*PortWidth  synchronised pin inputs to core
- gpio_out  out  NumGPIO*GPIOWidth  pin output data
- gpio_oe  out  NumGPIO*GPIOWidth  pin output enables
- gpio_in  in  NumGPIO*GPIOWidth  raw pin inputs
- busy  out  1  guard sequence in progress

Behaviour:
- Elaboration check: IOPorts*PortWidth ≤ NumGPIO*GPIOWidth, DB25Pins ≤ PortWidth, IOPorts ≤ 8; fatal error otherwise.
- Mapping: hm2 bit i ↔ gpio pin i (flat, header 0 first). Port p occupies bits p*PortWidth .. p*PortWidth+PortWidth-1.
- Unmapped gpio pins: gpio_oe=0, gpio_out=0 permanently.
- Output path: registered, 1-cycle latency hm2_out/hm2_oe → gpio_out/gpio_oe.
- In DB25 mode, port-relative pins ≥ DB25Pins are forced oe=0, out=0, hm2_in=0.
- Input path: SyncStages flops per pin, then masking, then hm2_in. Latency is SyncStages cycles.
- Reset (async assert, sync deassert, applied to all flops):
  - gpio_out=0, gpio_oe=0, hm2_in=0, bus_rdata=0, busy=0.
  - active_mode=pending_mode=DefaultMode; FSM=IDLE; guard counter=0.
- Register write (bus_we & bus_addr==ModeAddr):
  - pending_mode ← wdata[IOPorts-1:0].
  - If pending_mode ≠ active_mode: FSM → GUARD, counter ← GuardCycles.
- Register read, returned 1 cycle later:
  - [7:0] active_mode, zero-extended.
  - [23:16] pending_mode.
  - [31] busy.
  - Other bits 0.
  - Reads at any other address return 0.
- FSM:
  - IDLE: outputs follow active_mode.
  - GUARD: for each changing port (pending XOR active), all port pins get gpio_oe=0, gpio_out=0. Unchanged ports keep operating. Counter decrements each cycle; busy=1. At counter==1 → APPLY.
  - APPLY (1 cycle): active_mode ← pending_mode; busy=1; → IDLE.
- Write during GUARD:
  - If the new pending value differs from active: pending updates, the changing-port set is recomputed, and the counter reloads to GuardCycles.
  - If the new value equals active: abort to IDLE with no APPLY, and busy drops next cycle.
- Write during APPLY: the APPLY completes first; the new write is then evaluated against the updated active_mode in IDLE.
- Write equal to active_mode in IDLE: no state change.
- Simultaneous bus_we and bus_re at the same address: read returns the pre-write value.
- Reset mid-GUARD: everything returns to DefaultMode immediately; no glitch outputs are enabled.

Decomposition:
- Shared package hm2_adaptor_pkg:
  - typedef enum {ADP_STRAIGHT=0, ADP_DB25=1}.
  - FSM state enum {IDLE, GUARD, APPLY}.
  - Register field offsets.
  - Function port_mask(mode, port) returning the live-pin mask.
- Board packages set the per-board values of IOPorts, PortWidth, NumGPIO and GPIOWidth.
- One sub-module: hm2_pin_sync, a SyncStages-deep per-bit synchroniser vector. It is instantiated once with width NumGPIO*GPIOWidth.

Test Plan:
- Reset, then hm2_oe=all-1 and hm2_out=72'hAA..AA → 1 cycle later gpio_oe=all-1, gpio_out=72'hAA..AA. Register read returns 32'h0000_0000.
- gpio_in bit 5 pulses 0→1 → hm2_in[5] rises exactly 2 cycles later. A 1-cycle input pulse reaches the core as a 1-cycle pulse.
- Write 3'b010 with all oe=1:
  - Pins 24..47 get oe=0 for 4 cycles, then 1 APPLY cycle; ports 0 and 2 are unaffected throughout.
  - busy=1 for 5 cycles.
  - Afterwards pins 41..47 remain oe=0 and hm2_in[47:41]=0.
  - Read returns 32'h0002_0002.
- Write 3'b010 then 3'b110 two cycles later → guard reloads, ports 1 and 2 tristated together; busy=1 for 7 cycles total; final active_mode=3'b110.
- Write 3'b001 then 3'b000 one cycle later → abort. Port 0 oe restores the cycle after abort, no APPLY occurs, and active_mode stays 0.
- Assert reset_n=0 mid-GUARD → all gpio_oe=0 asynchronously. After release, active_mode=DefaultMode and busy=0.
